alu_issue: RTL and testbench

ALU_ISSUE -- requirements
Module: alu_issue

---
 rtl/alu_issue_pkg.sv | 55 +++++
 rtl/alu_issue_if.sv | 9 +
 rtl/alu_issue_regfile.sv | 25 ++
 rtl/alu_issue.sv | 121 ++++++++++++
 tb/tb_alu_issue.sv | 318 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_issue_pkg.sv
// Shared types and constants for the alu_issue block.
// Optional feature: define ALU_ISSUE_MUL_EN to make the multiply opcode legal.
package alu_issue_pkg;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_MUL = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_AND = 4'b0100;
    localparam logic [3:0] OP_XOR = 4'b0101;
    localparam logic [3:0] OP_LDI = 4'b1111;

    localparam logic [2:0] SR_NONE = 3'b000;
    localparam logic [2:0] SR_RSH  = 3'b001;
    localparam logic [2:0] SR_LSH  = 3'b010;
    localparam logic [2:0] SR_ROR  = 3'b011;

    // Instruction word field positions; imm overlaps rs1/rs2 and is only meaningful for LDI.
    localparam int OP_MSB   = 31;
    localparam int OP_LSB   = 28;
    localparam int SRC_MSB  = 27;
    localparam int SRC_LSB  = 25;
    localparam int SRB_MSB  = 24;
    localparam int SRB_LSB  = 20;
    localparam int RD_MSB   = 19;
    localparam int RD_LSB   = 17;
    localparam int RS1_MSB  = 16;
    localparam int RS1_LSB  = 14;
    localparam int RS2_MSB  = 13;
    localparam int RS2_LSB  = 11;
    localparam int IMM_MSB  = 16;
    localparam int IMM_LSB  = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WB    = 2'd2,
        ST_ERR   = 2'd3
    } state_t;

    function automatic logic op_is_alu(input logic [3:0] op);
        logic ok;
        case (op)
            OP_ADD, OP_SUB, OP_OR, OP_AND, OP_XOR: ok = 1'b1;
`ifdef ALU_ISSUE_MUL_EN
            OP_MUL: ok = 1'b1;
`else
            OP_MUL: ok = 1'b0;
`endif
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/alu_issue_if.sv
// Instruction handshake between an issuing master and the alu_issue block.
interface alu_issue_if;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;

    modport master (output instr_valid, output instr, input  instr_ready);
    modport slave  (input  instr_valid, input  instr, output instr_ready);
endinterface

// File: rtl/alu_issue_regfile.sv
// 8x32 register file: two asynchronous read ports, one synchronous write port, r0 hard-wired to zero.
module alu_issue_regfile (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  ra1,
    output logic [31:0] rd1,
    input  logic [2:0]  ra2,
    output logic [31:0] rd2,
    input  logic        we,
    input  logic [2:0]  wa,
    input  logic [31:0] wd
);
    logic [31:0] mem [0:7];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) mem[i] <= '0;
        end else if (we && (wa != 3'd0)) begin
            mem[wa] <= wd;
        end
    end

    assign rd1 = (ra1 == 3'd0) ? '0 : mem[ra1];
    assign rd2 = (ra2 == 3'd0) ? '0 : mem[ra2];
endmodule

// File: rtl/alu_issue.sv
// Single-issue sequencer: decodes one instruction at a time, drives an external ALU, writes back.
// Optional feature: ALU_ISSUE_MUL_EN enables the multiply opcode (see alu_issue_pkg::op_is_alu).
//
// state    | meaning
// ST_IDLE  | ready for an instruction; decode on accept
// ST_ISSUE | operands and controls on the ALU port, result captured at the edge
// ST_WB    | write result to rd, done pulse
// ST_ERR   | rejected instruction, illegal pulse
module alu_issue
    import alu_issue_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    alu_issue_if.slave  bus,
    output logic [31:0] alu_in1,
    output logic [31:0] alu_in2,
    output logic [3:0]  alu_opcode,
    output logic [2:0]  alu_sr_cont,
    output logic [4:0]  alu_sr_bit,
    input  logic [31:0] alu_out,
    output logic        done,
    output logic [2:0]  done_rd,
    output logic [31:0] done_data,
    output logic        illegal
);
    state_t      state, state_n;
    logic [3:0]  ir_op;
    logic [2:0]  ir_cont;
    logic [4:0]  ir_sb;
    logic [2:0]  ir_rd, ir_rs1, ir_rs2;
    logic [3:0]  in_op;
    logic [2:0]  in_cont;
    logic [31:0] rs1_data, rs2_data;
    logic        accept;

    assign in_op   = bus.instr[OP_MSB:OP_LSB];
    assign in_cont = bus.instr[SRC_MSB:SRC_LSB];
    assign accept  = (state == ST_IDLE) && bus.instr_valid;

    assign bus.instr_ready = (state == ST_IDLE);
    // Gated by rst so an instruction aborted in WB never reports or writes.
    assign done    = (state == ST_WB)  && !rst;
    assign illegal = (state == ST_ERR) && !rst;

    always_comb begin
        state_n = state;
        unique case (state)
            ST_IDLE: begin
                if (bus.instr_valid) begin
                    if (in_op == OP_LDI)                         state_n = ST_WB;
                    else if (op_is_alu(in_op) && !in_cont[2])    state_n = ST_ISSUE;
                    else                                         state_n = ST_ERR;
                end
            end
            ST_ISSUE: state_n = ST_WB;
            ST_WB:    state_n = ST_IDLE;
            ST_ERR:   state_n = ST_IDLE;
            default:  state_n = ST_IDLE;
        endcase
    end

    always_comb begin
        alu_in1     = '0;
        alu_in2     = '0;
        alu_opcode  = '0;
        alu_sr_cont = SR_NONE;
        alu_sr_bit  = '0;
        if (state == ST_ISSUE) begin
            alu_in1     = rs1_data;
            alu_in2     = rs2_data;
            alu_opcode  = ir_op;
            alu_sr_cont = ir_cont;
            alu_sr_bit  = ir_sb;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            ir_op     <= '0;
            ir_cont   <= '0;
            ir_sb     <= '0;
            ir_rd     <= '0;
            ir_rs1    <= '0;
            ir_rs2    <= '0;
            done_rd   <= '0;
            done_data <= '0;
        end else begin
            state <= state_n;
            if (accept) begin
                ir_op   <= in_op;
                ir_cont <= in_cont;
                ir_sb   <= bus.instr[SRB_MSB:SRB_LSB];
                ir_rd   <= bus.instr[RD_MSB:RD_LSB];
                ir_rs1  <= bus.instr[RS1_MSB:RS1_LSB];
                ir_rs2  <= bus.instr[RS2_MSB:RS2_LSB];
            end
            // done_rd/done_data load on entry to WB and hold afterwards.
            if (accept && (in_op == OP_LDI)) begin
                done_rd   <= bus.instr[RD_MSB:RD_LSB];
                done_data <= {15'b0, bus.instr[IMM_MSB:IMM_LSB]};
            end
            if (state == ST_ISSUE) begin
                done_rd   <= ir_rd;
                done_data <= alu_out;
            end
        end
    end

    alu_issue_regfile u_regfile (
        .clk (clk),
        .rst (rst),
        .ra1 (ir_rs1),
        .rd1 (rs1_data),
        .ra2 (ir_rs2),
        .rd2 (rs2_data),
        .we  (done),
        .wa  (done_rd),
        .wd  (done_data)
    );
endmodule

// File: tb/tb_alu_issue.sv
// Scoreboard bench for alu_issue: directed scenarios then randomized instructions against a reference model.
module tb_alu_issue;
    import alu_issue_pkg::*;

    localparam int K_ALU = 0;
    localparam int K_LDI = 1;
    localparam int K_ILL = 2;

    typedef struct {
        int          kind;
        int          edge_n;
        logic [2:0]  rd;
        logic [31:0] data;
        logic [31:0] in1;
        logic [31:0] in2;
        logic [3:0]  op;
        logic [2:0]  cont;
        logic [4:0]  sb;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] alu_in1, alu_in2, alu_out, done_data;
    logic [3:0]  alu_opcode;
    logic [2:0]  alu_sr_cont, done_rd;
    logic [4:0]  alu_sr_bit;
    logic        done, illegal;

    alu_issue_if bus();

    alu_issue dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .alu_in1     (alu_in1),
        .alu_in2     (alu_in2),
        .alu_opcode  (alu_opcode),
        .alu_sr_cont (alu_sr_cont),
        .alu_sr_bit  (alu_sr_bit),
        .alu_out     (alu_out),
        .done        (done),
        .done_rd     (done_rd),
        .done_data   (done_data),
        .illegal     (illegal)
    );

    always #5 clk = ~clk;

    int          cyc = 0;
    int          n_pass = 0;
    int          n_total = 0;
    exp_t        sbq[$];
    logic [31:0] mref [8];
    logic [2:0]  last_rd = '0;
    logic [31:0] last_data = '0;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural ALU standing in for the team ALU: operation, then optional shift/rotate.
    function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                            input logic [3:0] op, input logic [2:0] cont,
                                            input logic [4:0] sb);
        logic [31:0] r;
        logic [63:0] t;
        case (op)
            4'd0:    r = a + b;
            4'd1:    r = a - b;
            4'd2:    r = a * b;
            4'd3:    r = a | b;
            4'd4:    r = a & b;
            4'd5:    r = a ^ b;
            default: r = '0;
        endcase
        t = {r, r} >> sb;
        case (cont)
            3'd1:    r = r >> sb;
            3'd2:    r = r << sb;
            3'd3:    r = t[31:0];
            default: r = r;
        endcase
        return r;
    endfunction

    assign alu_out = ref_alu(alu_in1, alu_in2, alu_opcode, alu_sr_cont, alu_sr_bit);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [31:0] enc_alu(input int op, input int cont, input int sb,
                                            input int rd, input int rs1, input int rs2);
        return {op[3:0], cont[2:0], sb[4:0], rd[2:0], rs1[2:0], rs2[2:0], 11'b0};
    endfunction

    function automatic logic [31:0] enc_ldi(input int rd, input int imm);
        return {4'hF, 3'b0, 5'b0, rd[2:0], imm[16:0]};
    endfunction

    // Reference model: called just before the edge that accepts word w.
    task automatic model_accept(input logic [31:0] w);
        exp_t e;
        int   op, cont;
        bit   mul_ok;
`ifdef ALU_ISSUE_MUL_EN
        mul_ok = 1'b1;
`else
        mul_ok = 1'b0;
`endif
        op     = int'(w[31:28]);
        cont   = int'(w[27:25]);
        e.rd   = w[19:17];
        e.op   = w[31:28];
        e.cont = w[27:25];
        e.sb   = w[24:20];
        e.in1  = mref[w[16:14]];
        e.in2  = mref[w[13:11]];
        if (op == 15) begin
            e.kind   = K_LDI;
            e.data   = {15'b0, w[16:0]};
            e.edge_n = cyc + 1;
        end else if (op <= 5 && (op != 2 || mul_ok) && cont <= 3) begin
            e.kind   = K_ALU;
            e.data   = ref_alu(e.in1, e.in2, e.op, e.cont, e.sb);
            e.edge_n = cyc + 2;
        end else begin
            e.kind   = K_ILL;
            e.data   = '0;
            e.edge_n = cyc + 1;
        end
        if (e.kind != K_ILL && e.rd != 3'd0) mref[e.rd] = e.data;
        sbq.push_back(e);
    endtask

    always @(negedge clk) begin : monitor
        exp_t f;
        if (rst) begin
            last_rd   = '0;
            last_data = '0;
        end else begin
            if (!bus.instr_ready && !done && !illegal) begin
                chk("issue_expected", 64'(sbq.size() > 0 && sbq[0].kind == K_ALU), 64'd1);
                if (sbq.size() > 0 && sbq[0].kind == K_ALU) begin
                    chk("issue_in1", alu_in1, sbq[0].in1);
                    chk("issue_in2", alu_in2, sbq[0].in2);
                    chk("issue_ctrl", {alu_opcode, alu_sr_cont, alu_sr_bit},
                        {sbq[0].op, sbq[0].cont, sbq[0].sb});
                end
            end else begin
                chk("alu_idle_zero", {alu_in1, alu_in2}, 64'd0);
                chk("alu_idle_ctrl", {alu_opcode, alu_sr_cont, alu_sr_bit}, 64'd0);
            end
            if (done) begin
                chk("done_expected", 64'(sbq.size() > 0 && sbq[0].kind != K_ILL), 64'd1);
                if (sbq.size() > 0 && sbq[0].kind != K_ILL) begin
                    f = sbq.pop_front();
                    chk("done_rd", done_rd, f.rd);
                    chk("done_data", done_data, f.data);
                    chk("done_latency", cyc, f.edge_n);
                end
                last_rd   = done_rd;
                last_data = done_data;
            end else begin
                chk("done_hold", {done_rd, done_data}, {last_rd, last_data});
            end
            if (illegal) begin
                chk("illegal_expected", 64'(sbq.size() > 0 && sbq[0].kind == K_ILL), 64'd1);
                if (sbq.size() > 0 && sbq[0].kind == K_ILL) begin
                    f = sbq.pop_front();
                    chk("illegal_latency", cyc, f.edge_n);
                end
            end
        end
    end

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] w, input bit hold);
        int t = 0;
        bus.instr       = w;
        bus.instr_valid = 1'b1;
        while (!bus.instr_ready && t < 20) begin
            tick();
            t++;
        end
        if (!bus.instr_ready) begin
            chk("accept_timeout", 64'd0, 64'd1);
            bus.instr_valid = 1'b0;
            return;
        end
        model_accept(w);
        tick();
        if (!hold) bus.instr_valid = 1'b0;
    endtask

    task automatic drain;
        int t = 0;
        while ((sbq.size() > 0 || !bus.instr_ready) && t < 30) begin
            tick();
            t++;
        end
        chk("drain_empty", 64'(sbq.size()), 64'd0);
    endtask

    task automatic do_reset(input int n);
        rst             = 1'b1;
        bus.instr_valid = 1'b0;
        sbq.delete();
        for (int i = 0; i < 8; i++) mref[i] = '0;
        repeat (n) tick();
        rst = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        bus.instr_valid = 1'b0;
        bus.instr       = '0;
        for (int i = 0; i < 8; i++) mref[i] = '0;
        tick();
        do_reset(3);

        chk("reset_ready", bus.instr_ready, 64'd1);
        chk("reset_done_illegal", {done, illegal}, 64'd0);
        chk("reset_done_rd_data", {done_rd, done_data}, 64'd0);
        chk("reset_alu_out", {alu_in1, alu_in2}, 64'd0);
        chk("reset_alu_ctrl", {alu_opcode, alu_sr_cont, alu_sr_bit}, 64'd0);

        // LDI r1=5, LDI r2=3, ADD r3=r1+r2 -> 8
        send(enc_ldi(1, 5), 1'b0);
        drain();
        send(enc_ldi(2, 3), 1'b0);
        drain();
        send(enc_alu(0, 0, 0, 3, 1, 2), 1'b0);
        drain();
        chk("add_result", {done_rd, done_data}, {3'd3, 32'd8});

        // SUB with left shift by 2 on r1=20, r2=3
        send(enc_ldi(1, 20), 1'b0);
        drain();
        send(enc_alu(1, 2, 2, 4, 1, 2), 1'b0);
        drain();
        chk("sub_lsh_result", done_data, ref_alu(32'd20, 32'd3, 4'd1, 3'd2, 5'd2));

        // Illegal op and illegal shift control, then confirm registers unchanged
        send(enc_alu(7, 0, 0, 1, 1, 2), 1'b0);
        drain();
        send(enc_alu(0, 5, 0, 2, 1, 2), 1'b0);
        drain();
        send(enc_alu(0, 0, 0, 5, 1, 2), 1'b0);
        drain();
        chk("regs_after_illegal", {done_rd, done_data}, {3'd5, 32'd23});

        // MUL: legal only with the multiply option
        send(enc_ldi(1, 5), 1'b0);
        drain();
        send(enc_alu(2, 0, 0, 6, 1, 2), 1'b0);
        drain();
`ifdef ALU_ISSUE_MUL_EN
        chk("mul_result", {done_rd, done_data}, {3'd6, 32'd15});
`else
        chk("mul_rejected", {done_rd, done_data}, {3'd1, 32'd5});
`endif

        // valid held high across back-to-back dependent instructions
        send(enc_alu(0, 0, 0, 1, 1, 1), 1'b1);
        send(enc_alu(0, 0, 0, 1, 1, 1), 1'b1);
        send(enc_ldi(7, 17'h1ABCD), 1'b1);
        send(enc_alu(5, 3, 4, 7, 7, 1), 1'b0);
        drain();

        // reset during ISSUE aborts the instruction and clears registers
        send(enc_alu(0, 0, 0, 3, 1, 2), 1'b0);
        chk("in_issue_before_rst", bus.instr_ready, 64'd0);
        do_reset(1);
        repeat (3) tick();
        send(enc_alu(0, 0, 0, 4, 1, 2), 1'b0);
        drain();
        chk("regs_cleared", {done_rd, done_data}, {3'd4, 32'd0});
        send(enc_ldi(0, 7), 1'b0);
        drain();
        chk("ldi_r0_done", {done_rd, done_data}, {3'd0, 32'd7});
        send(enc_alu(3, 0, 0, 5, 0, 0), 1'b0);
        drain();
        chk("r0_reads_zero", done_data, 64'd0);

        // randomized instruction stream
        for (int i = 0; i < 150; i++) begin
            int          sel, op, cont;
            logic [31:0] w;
            bit          hold;
            sel  = $urandom_range(0, 9);
            cont = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 3) : $urandom_range(4, 7);
            if (sel <= 5)      op = sel;
            else if (sel == 7) op = $urandom_range(6, 14);
            else               op = 15;
            if (op == 15) w = enc_ldi($urandom_range(0, 7), $urandom_range(0, 131071));
            else          w = enc_alu(op, cont, $urandom_range(0, 31), $urandom_range(0, 7),
                                      $urandom_range(0, 7), $urandom_range(0, 7));
            hold = 1'($urandom_range(0, 1));
            send(w, hold);
            if (!hold) repeat ($urandom_range(0, 2)) tick();
        end
        bus.instr_valid = 1'b0;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
